arbitro_de_funcionalidade: RTL and testbench

ARBITRO_DE_FUNCIONALIDADE -- requirements
Module: arbitro_de_funcionalidade

---
 rtl/arbitro_de_funcionalidade.sv | 150 +++++++++++++++
 tb/tb_arbitro_de_funcionalidade.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_de_funcionalidade.sv
// rtl/arbitro_de_funcionalidade.sv - two-requester actuator arbiter with hold time, shared mode and optional autopilot
// Optional feature macro: ARB_PILOTO_AUTO_EN (autopilot takeover when both users present code 111)
`timescale 1ns/1ps
module arbitro_de_funcionalidade #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [2:0] User0,
    input  logic [2:0] User1,
    input  logic [2:0] Func0,
    input  logic [2:0] Func1,
    input  logic [1:0] Prio0,
    input  logic [1:0] Prio1,
    output logic       Grant0,
    output logic       Grant1,
    output logic [2:0] FuncOut,
    output logic [2:0] UserOut,
    output logic       Busy,
    output logic       PilotoAuto
);
    typedef enum logic [2:0] {
        IDLE,
        GRANT0,
        GRANT1,
        SHARED
`ifdef ARB_PILOTO_AUTO_EN
        , PILOT
`endif
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    state_t     arb_pick;
    logic [7:0] hold_cnt;
    logic       last_win;

    // Fresh arbitration; equal priority goes to whoever did not win last
    always_comb begin
        arb_pick = IDLE;
        if (Req0 && Req1) begin
            if (Func0 == Func1)
                arb_pick = SHARED;
            else if (Prio0 > Prio1)
                arb_pick = GRANT0;
            else if (Prio1 > Prio0)
                arb_pick = GRANT1;
            else
                arb_pick = last_win ? GRANT0 : GRANT1;
        end else if (Req0) begin
            arb_pick = GRANT0;
        end else if (Req1) begin
            arb_pick = GRANT1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            GRANT0: begin
                if (!Req0)
                    state_nx = arb_pick;
                else if (Req1) begin
                    if (Func0 == Func1)
                        state_nx = SHARED;
                    else if (hold_cnt == 8'd0 && Prio1 >= Prio0)
                        state_nx = GRANT1;
                end
            end
            GRANT1: begin
                if (!Req1)
                    state_nx = arb_pick;
                else if (Req0) begin
                    if (Func0 == Func1)
                        state_nx = SHARED;
                    else if (hold_cnt == 8'd0 && Prio0 >= Prio1)
                        state_nx = GRANT0;
                end
            end
            default: state_nx = arb_pick;
        endcase
`ifdef ARB_PILOTO_AUTO_EN
        if (Req0 && Req1 && User0 == 3'b111 && User1 == 3'b111)
            state_nx = PILOT;
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            last_win <= 1'b1;
            Grant0   <= 1'b0;
            Grant1   <= 1'b0;
            FuncOut  <= 3'b000;
            UserOut  <= 3'b000;
            Busy     <= 1'b0;
        end else begin
            state <= state_nx;
            // Hold window restarts only when ownership actually changes
            if (state_nx != state &&
                (state_nx == GRANT0 || state_nx == GRANT1 || state_nx == SHARED))
                hold_cnt <= HOLD_LOAD;
            else if (hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
            if (state_nx == GRANT0 && state != GRANT0)
                last_win <= 1'b0;
            else if (state_nx == GRANT1 && state != GRANT1)
                last_win <= 1'b1;
            Grant0 <= (state_nx == GRANT0) || (state_nx == SHARED);
            Grant1 <= (state_nx == GRANT1) || (state_nx == SHARED);
            Busy   <= (state_nx != IDLE);
            case (state_nx)
                GRANT0, SHARED: begin
                    FuncOut <= Func0;
                    UserOut <= User0;
                end
                GRANT1: begin
                    FuncOut <= Func1;
                    UserOut <= User1;
                end
`ifdef ARB_PILOTO_AUTO_EN
                PILOT: begin
                    FuncOut <= 3'b101;
                    UserOut <= 3'b111;
                end
`endif
                default: begin
                    FuncOut <= 3'b000;
                    UserOut <= 3'b000;
                end
            endcase
        end
    end

`ifdef ARB_PILOTO_AUTO_EN
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            PilotoAuto <= 1'b0;
        else
            PilotoAuto <= (state_nx == PILOT);
    end
`else
    assign PilotoAuto = 1'b0;
`endif
endmodule

// File: tb/tb_arbitro_de_funcionalidade.sv
// tb/tb_arbitro_de_funcionalidade.sv - scoreboard bench for arbitro_de_funcionalidade with HOLD_CYCLES=4
`timescale 1ns/1ps
module tb_arbitro_de_funcionalidade;
    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Req0, Req1;
    logic [2:0] User0, User1, Func0, Func1;
    logic [1:0] Prio0, Prio1;
    logic       Grant0, Grant1, Busy, PilotoAuto;
    logic [2:0] FuncOut, UserOut;

    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs;

    arbitro_de_funcionalidade #(.HOLD_CYCLES(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1),
        .User0(User0), .User1(User1),
        .Func0(Func0), .Func1(Func1),
        .Prio0(Prio0), .Prio1(Prio1),
        .Grant0(Grant0), .Grant1(Grant1),
        .FuncOut(FuncOut), .UserOut(UserOut),
        .Busy(Busy), .PilotoAuto(PilotoAuto)
    );

    always #5 Clock = ~Clock;

    // Observed word layout: {Grant0, Grant1, FuncOut, UserOut, Busy, PilotoAuto}
    assign obs = {Grant0, Grant1, FuncOut, UserOut, Busy, PilotoAuto};

    function automatic logic [11:0] ex(input int g0, input int g1, input int f,
                                       input int u, input int b, input int p);
        logic [11:0] w;
        w = {g0[0], g1[0], f[2:0], u[2:0], b[0], p[0]};
        return w;
    endfunction

    task automatic drive(input int r0, input int r1, input int f0, input int f1,
                         input int u0, input int u1, input int p0, input int p1);
        Req0 = r0[0];  Req1 = r1[0];
        Func0 = f0[2:0]; Func1 = f1[2:0];
        User0 = u0[2:0]; User1 = u1[2:0];
        Prio0 = p0[1:0]; Prio1 = p1[1:0];
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        drive(1, 0, 1, 0, 2, 0, 1, 0);
        Reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1: exp_q.push_back(12'd0);
                2: begin
                    Reset_n = 1'b1;
                    exp_q.push_back(ex(1, 0, 1, 2, 1, 0));
                end
                default: begin
                    drive(0, 0, 1, 0, 2, 0, 1, 0);
                    exp_q.push_back(12'd0);
                end
            endcase
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_rotation();
        logic [11:0] e;
        do_reset();
        drive(1, 1, 2, 3, 1, 2, 1, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < 4 || i == 8)
                exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
            else
                exp_q.push_back(ex(0, 1, 3, 2, 1, 0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rotation[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_preempt();
        logic [11:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1, 0, 2, 3, 1, 2, 1, 2);
            else        drive(1, 1, 2, 3, 1, 2, 1, 2);
            if (i < 4) exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
            else       exp_q.push_back(ex(0, 1, 3, 2, 1, 0));
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL preempt_hi[%0d] got=%b exp=%b", i, obs, e);
            end
        end
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive(1, 1, 2, 3, 1, 2, 1, 0);
                exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
            end else begin
                drive(0, 1, 2, 3, 1, 2, 1, 0);
                exp_q.push_back(ex(0, 1, 3, 2, 1, 0));
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL preempt_lo[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_shared();
        logic [11:0] e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1: begin
                    drive(1, 1, 1, 1, 3, 4, 1, 1);
                    exp_q.push_back(ex(1, 1, 1, 3, 1, 0));
                end
                2: begin
                    drive(0, 1, 1, 1, 3, 4, 1, 1);
                    exp_q.push_back(ex(0, 1, 1, 4, 1, 0));
                end
                3: begin
                    drive(1, 0, 1, 1, 3, 4, 1, 1);
                    exp_q.push_back(ex(1, 0, 1, 3, 1, 0));
                end
                4: begin
                    drive(1, 1, 1, 1, 3, 4, 1, 1);
                    exp_q.push_back(ex(1, 1, 1, 3, 1, 0));
                end
                5: begin
                    drive(1, 1, 1, 6, 3, 4, 1, 1);
                    exp_q.push_back(ex(0, 1, 6, 4, 1, 0));
                end
                default: begin
                    drive(0, 0, 1, 6, 3, 4, 1, 1);
                    exp_q.push_back(12'd0);
                end
            endcase
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL shared[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                drive(0, 1, 2, 3, 1, 2, 1, 1);
                exp_q.push_back(ex(0, 1, 3, 2, 1, 0));
            end else begin
                drive(1, 0, 2, 3, 1, 2, 1, 1);
                exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_pilot();
        logic [11:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                drive(1, 1, 2, 3, 7, 7, 1, 1);
`ifdef ARB_PILOTO_AUTO_EN
                exp_q.push_back(ex(0, 0, 5, 7, 1, 1));
`else
                exp_q.push_back(ex(1, 0, 2, 7, 1, 0));
`endif
            end else begin
                drive(1, 0, 2, 3, 7, 7, 1, 1);
                exp_q.push_back(ex(1, 0, 2, 7, 1, 0));
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL pilot[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [11:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1, 0, 2, 3, 1, 2, 1, 1);
                    exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
                end
                1: begin
                    Reset_n = 1'b0;
                    exp_q.push_back(12'd0);
                end
                default: begin
                    Reset_n = 1'b1;
                    drive(1, 1, 2, 3, 1, 2, 1, 1);
                    exp_q.push_back(ex(1, 0, 2, 1, 1, 0));
                end
            endcase
            tick();
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid[%0d] got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_rotation();
        test_preempt();
        test_shared();
        test_back_to_back();
        test_pilot();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
